// File: rtl/match_gaussian_if.sv
// Handshake/operand bundle between a Gaussian-match requester and match_gaussian.
interface match_gaussian_if;
   localparam int unsigned DW = 32;

   logic          en_match;
   logic [DW-1:0] grey;
   logic [DW-1:0] in_mugreyi;
   logic [DW-1:0] in_sigmai;
   logic          rd_match;
   logic          match;
   logic          busy;
   logic [DW-1:0] out_grey;
   logic [DW-1:0] out_mugreyi;
   logic [DW-1:0] out_sigmai;

   modport master (
      output en_match, grey, in_mugreyi, in_sigmai,
      input  rd_match, match, busy, out_grey, out_mugreyi, out_sigmai
   );

   modport slave (
      input  en_match, grey, in_mugreyi, in_sigmai,
      output rd_match, match, busy, out_grey, out_mugreyi, out_sigmai
   );
endinterface

// File: rtl/match_gaussian.sv
// Decides whether a grey pixel lies within THR_K*sigma of a Gaussian mean, using
// strobe-handshaked single-precision add and multiply cores.
module match_gaussian_fp_core #(
   parameter bit          IS_MUL = 1'b0,
   parameter int unsigned LAT    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {C_LOAD, C_RUN, C_OUT} cstate_t;

   cstate_t     state_q, state_n;
   logic        got_a_q, got_b_q;
   logic [31:0] a_q, b_q, z_q, result_c;
   logic [7:0]  cnt_q;

   // Round-to-nearest-even packing of a normalised 24-bit significand.
   function automatic logic [31:0] fp_pack(input logic s, input logic signed [10:0] e,
                                           input logic [23:0] m, input logic g, input logic st);
      logic [24:0]        mr;
      logic signed [10:0] er;
      mr = {1'b0, m} + 25'(g & (st | m[0]));
      er = e;
      if (mr[24]) begin
         mr = mr >> 1;
         er = er + 11'sd1;
      end
      if (er >= 11'sd255) return {s, 8'hFF, 23'd0};
      else if (er <= 11'sd0) return {s, 31'd0};
      else return {s, er[7:0], mr[22:0]};
   endfunction

   // Denormal operands are treated as zero.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]        x, y;
      logic [26:0]        mx, my, sh;
      logic [27:0]        sum;
      logic [7:0]         d;
      logic               sticky;
      logic signed [10:0] e;
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
         return QNAN;
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) return (a[31] != b[31]) ? QNAN : a;
      if (a[30:23] == 8'hFF) return a;
      if (b[30:23] == 8'hFF) return b;
      if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
      if (a[30:23] == 8'd0) return b;
      if (b[30:23] == 8'd0) return a;
      if (a[30:0] >= b[30:0]) begin
         x = a; y = b;
      end else begin
         x = b; y = a;
      end
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      d  = x[30:23] - y[30:23];
      if (d >= 8'd27) begin
         sh     = 27'd0;
         sticky = 1'b1;
      end else begin
         sh     = my >> d;
         sticky = ((sh << d) != my);
      end
      sh[0] = sh[0] | sticky;
      e = $signed({3'b000, x[30:23]});
      if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, sh};
      else                sum = {1'b0, mx} - {1'b0, sh};
      if (sum == 28'd0) return 32'd0;
      if (sum[27]) begin
         sum = {1'b0, sum[27:2], sum[1] | sum[0]};
         e   = e + 11'sd1;
      end else begin
         for (int i = 0; i < 27; i++) begin
            if (!sum[26]) begin
               sum = sum << 1;
               e   = e - 11'sd1;
            end
         end
      end
      return fp_pack(x[31], e, sum[26:3], sum[2], sum[1] | sum[0]);
   endfunction

   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic               s, a_inf, b_inf, a_zero, b_zero;
      logic [47:0]        p;
      logic signed [10:0] e;
      s      = a[31] ^ b[31];
      a_inf  = (a[30:23] == 8'hFF);
      b_inf  = (b[30:23] == 8'hFF);
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      if ((a_inf && a[22:0] != 23'd0) || (b_inf && b[22:0] != 23'd0)) return QNAN;
      if ((a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
      if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {s, 31'd0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
      if (p[47]) return fp_pack(s, e + 11'sd1, p[47:24], p[23], |p[22:0]);
      else       return fp_pack(s, e, p[46:23], p[22], |p[21:0]);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= C_LOAD;
      else     state_q <= state_n;
   end

   always_comb begin
      state_n      = state_q;
      output_z_stb = 1'b0;
      result_c     = IS_MUL ? fp_mul(a_q, b_q) : fp_add(a_q, b_q);
      case (state_q)
         C_LOAD: if (got_a_q && got_b_q) state_n = C_RUN;
         C_RUN:  if (cnt_q == 8'(LAT - 1)) state_n = C_OUT;
         C_OUT: begin
            output_z_stb = 1'b1;
            if (output_z_ack) state_n = C_LOAD;
         end
         default: state_n = C_LOAD;
      endcase
   end

   // Operand capture and the fixed-latency compute pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         got_a_q <= 1'b0;
         got_b_q <= 1'b0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         z_q     <= 32'd0;
         cnt_q   <= 8'd0;
      end else begin
         case (state_q)
            C_LOAD: begin
               cnt_q <= 8'd0;
               if (input_a_stb) begin
                  a_q     <= input_a;
                  got_a_q <= 1'b1;
               end
               if (input_b_stb) begin
                  b_q     <= input_b;
                  got_b_q <= 1'b1;
               end
            end
            C_RUN: begin
               cnt_q <= cnt_q + 8'd1;
               if (state_n == C_OUT) z_q <= result_c;
            end
            C_OUT: if (output_z_ack) begin
               got_a_q <= 1'b0;
               got_b_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign output_z = z_q;
endmodule

module match_gaussian #(
   parameter logic [31:0] THR_K = 32'h4020_0000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   match_gaussian_if.slave   bus
);
   localparam int unsigned DW = 32;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CMP, S_DONE} state_t;

   state_t        state_q, state_n;
   logic [DW-1:0] grey_q, mu_q, sigma_q;
   logic [DW-1:0] add_z, mul_z, add_q, mul_q, absd_c, thr_c;
   logic          add_stb, mul_stb, got_add_q, got_mul_q;
   logic          issue_c, collect_c, cmp_c;
   logic          rd_q, match_q, busy_q;

   match_gaussian_fp_core #(.IS_MUL(1'b0), .LAT(3)) u_add (
      .clk(clk_i), .rst(rst_i),
      .input_a(grey_q),                  .input_a_stb(issue_c),
      .input_b({1'b1, mu_q[DW-2:0]}),    .input_b_stb(issue_c),
      .output_z(add_z), .output_z_stb(add_stb), .output_z_ack(1'b1)
   );

   match_gaussian_fp_core #(.IS_MUL(1'b1), .LAT(1)) u_mul (
      .clk(clk_i), .rst(rst_i),
      .input_a(sigma_q), .input_a_stb(issue_c),
      .input_b(THR_K),   .input_b_stb(issue_c),
      .output_z(mul_z), .output_z_stb(mul_stb), .output_z_ack(1'b1)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_n;
   end

   // A strobe arriving in the same cycle as the check counts, giving a two-cycle tail.
   always_comb begin
      state_n   = state_q;
      issue_c   = (state_q == S_ISSUE);
      collect_c = (state_q == S_ISSUE) || (state_q == S_WAIT);
      absd_c    = add_q & 32'h7FFF_FFFF;
      thr_c     = mul_q & 32'h7FFF_FFFF;
      cmp_c     = (absd_c[30:23] != 8'hFF) && (thr_c[30:23] != 8'hFF) && (absd_c < thr_c);
      case (state_q)
         S_IDLE:  if (bus.en_match) state_n = S_ISSUE;
         S_ISSUE: state_n = S_WAIT;
         S_WAIT:  if ((got_add_q || add_stb) && (got_mul_q || mul_stb)) state_n = S_CMP;
         S_CMP:   state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Core results are only collected while a request is in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         got_add_q <= 1'b0;
         got_mul_q <= 1'b0;
         add_q     <= '0;
         mul_q     <= '0;
      end else begin
         if (collect_c && add_stb) add_q <= add_z;
         if (collect_c && mul_stb) mul_q <= mul_z;
         if (state_n == S_CMP) begin
            got_add_q <= 1'b0;
            got_mul_q <= 1'b0;
         end else if (collect_c) begin
            if (add_stb) got_add_q <= 1'b1;
            if (mul_stb) got_mul_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         grey_q  <= '0;
         mu_q    <= '0;
         sigma_q <= '0;
         rd_q    <= 1'b0;
         match_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         busy_q <= (state_n != S_IDLE);
         rd_q   <= (state_n == S_DONE);
         if (state_q == S_IDLE && bus.en_match) begin
            grey_q  <= bus.grey;
            mu_q    <= bus.in_mugreyi;
            sigma_q <= bus.in_sigmai;
         end
         if (state_q == S_CMP) match_q <= cmp_c;
      end
   end

   assign bus.rd_match    = rd_q;
   assign bus.match       = match_q;
   assign bus.busy        = busy_q;
   assign bus.out_grey    = grey_q;
   assign bus.out_mugreyi = mu_q;
   assign bus.out_sigmai  = sigma_q;
endmodule

// File: tb/tb_match_gaussian.sv
// Scoreboard bench for match_gaussian: the driver queues expected results on each
// accepted start, a monitor pops and compares on every rd_match.
module tb_match_gaussian;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   match_gaussian_if mg ();
   match_gaussian #(.THR_K(32'h4020_0000)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(mg));

   typedef struct packed {
      logic        m;
      logic [31:0] g;
      logic [31:0] mu;
      logic [31:0] s;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_chk = 0, n_pass = 0, n_acc = 0, n_abort = 0, n_rd = 0;
   bit   model_idle = 1'b1, done_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, req, $time);
   endtask

   // Exact single-precision encoding of n * 2^adj for small positive integers n.
   function automatic logic [31:0] to_f32(input int n, input int adj);
      int          p;
      logic [31:0] u;
      if (n == 0) return 32'd0;
      p = 0;
      for (int i = 0; i < 24; i++) if (n[i]) p = i;
      u = 32'(n) << (23 - p);
      return {1'b0, 8'(127 + p + adj), u[22:0]};
   endfunction

   task automatic drive(input logic en, input logic [31:0] g, input logic [31:0] mu,
                        input logic [31:0] s, input logic m);
      exp_t e;
      @(negedge clk_i);
      mg.en_match   = en;
      mg.grey       = g;
      mg.in_mugreyi = mu;
      mg.in_sigmai  = s;
      @(posedge clk_i);
      if (en && model_idle && !rst_i) begin
         e.m = m; e.g = g; e.mu = mu; e.s = s;
         sbq.push_back(e);
         model_idle = 1'b0;
         n_acc++;
      end
   endtask

   task automatic settle();
      int i;
      i = 0;
      while ((!model_idle || sbq.size() != 0) && i < 100) begin
         drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
         i++;
      end
      check("settle_in_time", 32'(i < 100), 32'd1);
   endtask

   task automatic run_vec(input logic [31:0] g, input logic [31:0] mu, input logic [31:0] s,
                          input logic m);
      drive(1'b1, g, mu, s, m);
      settle();
   endtask

   // Monitor: busy must track the in-flight model every cycle; rd_match pops the scoreboard.
   always @(posedge clk_i) begin
      #1;
      if (!rst_i) begin
         if (done_seen) begin
            model_idle = 1'b1;
            done_seen  = 1'b0;
         end
         check("busy", 32'(mg.busy), 32'(!model_idle));
         if (mg.rd_match) begin
            n_rd++;
            done_seen = 1'b1;
            if (sbq.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_rd_match: got rd_match=1, expected none (t=%0t)", $time);
            end else begin
               mon_e = sbq.pop_front();
               check("match", 32'(mg.match), 32'(mon_e.m));
               check("out_grey", mg.out_grey, mon_e.g);
               check("out_mugreyi", mg.out_mugreyi, mon_e.mu);
               check("out_sigmai", mg.out_sigmai, mon_e.s);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   g, mu, k;
      real  d;
      logic m;
      mg.en_match = 1'b0; mg.grey = '0; mg.in_mugreyi = '0; mg.in_sigmai = '0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_busy", 32'(mg.busy), 32'd0);
      check("rst_rd_match", 32'(mg.rd_match), 32'd0);
      check("rst_match", 32'(mg.match), 32'd0);
      check("rst_out_grey", mg.out_grey, 32'd0);
      rst_i = 1'b0;

      run_vec(32'h42C8_0000, 32'h42C4_0000, 32'h3F80_0000, 1'b1); // |2| < 2.5
      run_vec(32'h42C8_0000, 32'h42CE_0000, 32'h3F80_0000, 1'b0); // |3| >= 2.5
      run_vec(32'h42C8_0000, 32'h42C5_8000, 32'h3F00_0000, 1'b0); // 1.25 == 1.25
      run_vec(32'h42C8_0000, 32'h42C8_0000, 32'h0000_0000, 1'b0); // sigma 0
      run_vec(32'h42C8_0000, 32'h42C8_0000, 32'h7F80_0000, 1'b0); // sigma Inf
      run_vec(32'h42C8_0000, 32'h42C8_0000, 32'h3F80_0000, 1'b1); // zero diff
      run_vec(32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 1'b1); // +0 - (-0)
      run_vec(32'h42C4_0000, 32'h42C8_0000, 32'h3F80_0000, 1'b1); // negative diff

      // en_match held high; operands change after the first accepted start.
      drive(1'b1, 32'h42C8_0000, 32'h42C4_0000, 32'h3F80_0000, 1'b1);
      repeat (19) drive(1'b1, 32'h42C8_0000, 32'h42CE_0000, 32'h3F80_0000, 1'b0);
      settle();

      // Reset while waiting on the cores: outputs clear without a clock edge.
      run_vec(32'h42C8_0000, 32'h42C4_0000, 32'h3F80_0000, 1'b1);
      drive(1'b1, 32'h42C8_0000, 32'h42CE_0000, 32'h4000_0000, 1'b1);
      @(posedge clk_i);
      #3;
      rst_i       = 1'b1;
      mg.en_match = 1'b0;
      sbq.delete();
      model_idle  = 1'b1;
      done_seen   = 1'b0;
      n_abort++;
      #1;
      check("async_rst_busy", 32'(mg.busy), 32'd0);
      check("async_rst_match", 32'(mg.match), 32'd0);
      check("async_rst_rd_match", 32'(mg.rd_match), 32'd0);
      check("async_rst_out_grey", mg.out_grey, 32'd0);
      check("async_rst_out_mugreyi", mg.out_mugreyi, 32'd0);
      check("async_rst_out_sigmai", mg.out_sigmai, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (12) drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      run_vec(32'h42C8_0000, 32'h42CE_0000, 32'h4000_0000, 1'b1); // |3| < 5

      // Integer grey/mu in 0..255, sigma = k/2 in 0.5..64; all values exact in single.
      for (int n = 0; n < 1000; n++) begin
         g  = int'($urandom_range(255));
         mu = int'($urandom_range(255));
         k  = int'($urandom_range(128, 1));
         d  = real'(g) - real'(mu);
         if (d < 0.0) d = -d;
         m  = (d < 2.5 * (real'(k) * 0.5));
         run_vec(to_f32(g, 0), to_f32(mu, 0), to_f32(k, -1), m);
      end

      settle();
      check("rd_count", 32'(n_rd), 32'(n_acc - n_abort));
      check("queue_empty", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/match_gaussian.md
MATCH_GAUSSIAN -- requirements
Module: match_gaussian

Interface
REQ-001 Parameter THR_K, default 32'h40200000 (2.5), IEEE-754 single match-threshold multiplier applied to sigma.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 en_match  input  1  start strobe; sampled only in IDLE.
REQ-005 grey  input  32  pixel value, IEEE-754 single.
REQ-006 in_mugreyi  input  32  Gaussian mean, IEEE-754 single.
REQ-007 in_sigmai  input  32  Gaussian std-dev, IEEE-754 single, non-negative.
REQ-008 rd_match  output  1  one-cycle done pulse; result valid in the same cycle.
REQ-009 match  output  1  1 when |grey - mu| < THR_K*sigma.
REQ-010 busy  output  1  high from the accepted start until rd_match, inclusive.
REQ-011 out_grey, out_mugreyi, out_sigmai  output  32 each  operands captured at start; held stable until the next accepted start (feed updateMuSigma).

Function
REQ-012 On en_match=1 in IDLE: capture grey, in_mugreyi, in_sigmai into holding registers; go to ISSUE.
REQ-013 en_match while busy=1 SHALL be ignored; no queuing, no change to captured operands.
REQ-014 ISSUE (1 cycle): pulse input_a_stb/input_b_stb of one adder (captured grey, mu with sign bit forced to 1) and one multiplier (captured sigma, THR_K) simultaneously; go to WAIT.
REQ-015 Both cores are instantiated with output_z_ack tied to 1; each result SHALL be latched into its own register on its output_z_stb, with its own sticky got flag.
REQ-016 WAIT: remain until both got flags are set, in either order or in the same cycle; then go to CMP and clear both flags.
REQ-017 CMP (1 cycle): absd = diff with bit31 cleared; thr = product with bit31 cleared.
REQ-018 CMP compares absd[30:0] < thr[30:0] as unsigned integers; this is valid for non-negative non-NaN singles.
REQ-019 If either exponent field is 8'hFF (Inf/NaN), match SHALL be 0.
REQ-020 CMP registers match and goes to DONE.
REQ-021 DONE (1 cycle): rd_match=1, then return to IDLE; a new start may be accepted in the cycle after DONE.
REQ-022 match holds its value until the next CMP.
REQ-023 rd_match is never asserted outside DONE.
REQ-024 Latency: rd_match = 2 cycles after the later of the two core output_z_stb pulses; it is otherwise unbounded only by core latency.
REQ-025 Boundaries:
- sigma=0 gives thr=0; match=0, including when grey==mu, because the comparison is strict.
- absd==thr exactly gives match=0.
- +0/-0 difference gives absd=0.
REQ-026 Stray output_z_stb pulses in IDLE SHALL be ignored and SHALL NOT set the got flags.

Reset
REQ-027 rst_i=1 at any time, including mid-WAIT, forces IDLE, clears both got flags, and sets rd_match=0, match=0, busy=0, and out_grey/out_mugreyi/out_sigmai=0.
REQ-028 rst_i drives the rst port of both FP cores so that in-flight operations are discarded.
REQ-029 After rst_i deasserts, the first en_match is accepted normally.

Verification
REQ-030 grey=42C80000 (100.0), mu=42C40000 (98.0), sigma=3F800000 (1.0), en_match pulse -> one rd_match pulse, match=1 (|2|<2.5), out_* echo the inputs.
REQ-031 grey=42C80000, mu=42CE0000 (103.0), sigma=3F800000 -> match=0 (3 >= 2.5). Repeat with sigma=3F000000 (0.5) and grey-mu=1.25 (mu=42C58000): equality case -> match=0.
REQ-032 grey=mu=42C80000, sigma=00000000 -> match=0. Then sigma=7F800000 (Inf) -> match=0.
REQ-033 Start accepted; en_match held high for 20 cycles -> exactly one rd_match per accepted start, busy high throughout. Operands changed during busy do not alter out_* or match.
REQ-034 Assert rst_i in WAIT, before either core result returns -> all outputs 0 immediately (asynchronous), no rd_match afterwards. New start after release -> correct result.
REQ-035 Randomised 1000 vectors against a real-valued model (grey 0-255, sigma 0.5-64): match agrees on every vector, and rd_match count equals the accepted-start count.
